bram_access_ctrl: RTL and testbench
===================================

// Module: bram_access_ctrl
// PURPOSE
//   Initiator side of the single-port vector BRAM: accepts burst load/store requests from
//   the SIMD datapath over a valid/ready handshake and sequences them onto the BRAM
//   addr/data_in/we/re port. Handles the BRAM's 1-cycle registered read latency, streams
//   write beats in and read beats out, and reports completion with a done pulse.
// PARAMETERS
//   DATA_WIDTH  128  width of one vector beat; matches the BRAM word
//   DEPTH       256  BRAM words; AW = $clog2(DEPTH)
//   LEN_W       4    burst length field width; bursts of 1..2**LEN_W beats
// PORTS
//   clk          in   1           single clock, all logic on rising edge
//   rst          in   1           asynchronous, active-high reset
//   req_valid    in   1           request present
//   req_ready    out  1           controller can accept a request
//   req_we       in   1           1 = store burst, 0 = load burst
//   req_addr     in   AW          base word address
//   req_len      in   LEN_W       beats minus one
//   wdata        in   DATA_WIDTH  store beat data
//   wdata_valid  in   1           store beat present
//   wdata_ready  out  1           store beat accepted
//   rdata        out  DATA_WIDTH  load beat data
//   rdata_valid  out  1           load beat valid (no backpressure)
//   done         out  1           one-cycle pulse: burst complete
//   busy         out  1           burst in progress (state != IDLE)
//   mem_addr     out  AW          to BRAM addr
//   mem_data_in  out  DATA_WIDTH  to BRAM data_in
//   mem_we       out  1           to BRAM we
//   mem_re       out  1           to BRAM re
//   mem_data_out in   DATA_WIDTH  from BRAM data_out, valid 1 cycle after re sampled
// BEHAVIOUR
//   - Reset: state IDLE, beat counter 0, read-pending flag 0, done 0, busy 0,
//     mem_we/mem_re/wdata_ready/rdata_valid 0, mem_addr 0, req_ready 1.
//   - States: IDLE, WRITE, READ, DRAIN. req_ready = (state==IDLE); request latched on
//     req_valid&&req_ready (base, len, we); req_valid ignored in every other state.
//   - IDLE -> WRITE if req_we else READ; beat counter cleared.
//   - WRITE: wdata_ready=1; mem_we=wdata_valid; mem_data_in=wdata; mem_addr=base+beat.
//     Beat advances only on wdata_valid; gaps allowed. Last beat accepted -> IDLE.
//   - READ: mem_re=1 every cycle, mem_addr=base+beat, beat++ per cycle; after issuing
//     beat len -> DRAIN. DRAIN: no issue, waits for last return -> IDLE.
//   - Read return: pending flag = registered mem_re; rdata_valid = flag;
//     rdata = mem_data_out. Beat k issued in cycle 1+k after accept, returned in 2+k.
//   - done: registered, high exactly one cycle, the first IDLE cycle after a burst.
//     A request accepted in that cycle is legal (back-to-back bursts, no bubble beyond it).
//   - Address arithmetic modulo DEPTH: base+beat truncated to AW bits (0xFF+1 -> 0x00).
//   - mem_we and mem_re never high in the same cycle; mem outputs 0 in IDLE.
//   - Reset mid-burst: abort immediately; in-flight read return dropped (rdata_valid 0);
//     no done; partially written words stay in BRAM. Normal operation after deassert.
// TESTING
//   1. Store len=0 addr 0x01 data A5A5..A5, then load 0x01 -> mem_we one cycle;
//      rdata_valid exactly 2 cycles after load accept, rdata=A5A5..A5; done once each.
//   2. Store len=3 at 0x10 with wdata_valid low 2 cycles between beats 1 and 2 ->
//      mem_we only on valid cycles, mem_addr 0x10..0x13 in order, done after beat 3.
//   3. Load len=3 at 0x10 -> mem_re 4 consecutive cycles, 4 consecutive rdata_valid,
//      data matches step 2, then 1 DRAIN cycle, done, req_ready=1.
//   4. Store len=2 at 0xFE (5A5A..5A) -> mem_addr 0xFE,0xFF,0x00; load back matches.
//   5. Load len=7, assert rst after 2 returns -> mem_re, rdata_valid, busy low at once,
//      no done; after release a len=0 load at 0x02 completes normally.
//   6. Hold req_valid during a burst -> req_ready 0, not accepted; accepted in done
//      cycle, second burst starts the following cycle.

Source files
------------

// File: rtl/bram_access_ctrl_if.sv
// Datapath-side request/stream bundle of the vector BRAM access controller.
// The controller uses the slave modport; the SIMD datapath uses the master modport.
interface bram_access_ctrl_if #(
  parameter int DATA_WIDTH = 128,
  parameter int AW         = 8,
  parameter int LEN_W      = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [AW-1:0]         req_addr;
  logic [LEN_W-1:0]      req_len;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_valid;
  logic                  done;
  logic                  busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_len, wdata, wdata_valid,
    output req_ready, wdata_ready, rdata, rdata_valid, done, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_len, wdata, wdata_valid,
    input  req_ready, wdata_ready, rdata, rdata_valid, done, busy
  );
endinterface

// File: rtl/bram_access_ctrl.sv
// Burst load/store sequencer for a single-port vector BRAM with 1-cycle registered read latency.
// Streams write beats in, read beats out, and pulses done on the first idle cycle after a burst.
module bram_access_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 256,
  parameter int LEN_W      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  bram_access_ctrl_if.slave     dp,
  output logic [AW-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_q;
  logic             pend_q;
  logic             done_q;

  logic             accept;
  logic             last_beat;
  logic [AW-1:0]    beat_addr;

  assign accept    = dp.req_valid && (state_q == IDLE);
  assign last_beat = (beat_q == len_q);
  // Wraps modulo DEPTH by truncation to AW bits.
  assign beat_addr = base_q + AW'(beat_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = dp.req_we ? WRITE : READ;
      WRITE:   if (dp.wdata_valid && last_beat) state_d = IDLE;
      READ:    if (last_beat) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= mem_re;
      done_q  <= (state_q != IDLE) && (state_d == IDLE);
      if (accept) begin
        base_q <= dp.req_addr;
        len_q  <= dp.req_len;
        beat_q <= '0;
      end else if ((state_q == WRITE && dp.wdata_valid) || state_q == READ) begin
        beat_q <= beat_q + LEN_W'(1);
      end
    end
  end

  always_comb begin
    mem_we      = (state_q == WRITE) && dp.wdata_valid;
    mem_re      = (state_q == READ);
    mem_addr    = (state_q == WRITE || state_q == READ) ? beat_addr : '0;
    mem_data_in = (state_q == WRITE) ? dp.wdata : '0;
  end

  assign dp.req_ready   = (state_q == IDLE);
  assign dp.wdata_ready = (state_q == WRITE);
  assign dp.busy        = (state_q != IDLE);
  assign dp.done        = done_q;
  assign dp.rdata_valid = pend_q;
  assign dp.rdata       = mem_data_out;

endmodule

// File: tb/tb_bram_access_ctrl.sv
// Randomized bench for bram_access_ctrl: a cycle-timed behavioural model checks every output
// each cycle, and directed scenarios pin the model with hand-computed expectations.
module tb_bram_access_ctrl;
  localparam int DW    = 128;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int LW    = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_data_out;

  bram_access_ctrl_if #(.DATA_WIDTH(DW), .AW(AW), .LEN_W(LW)) bus ();

  bram_access_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .dp           (bus),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_data_out (mem_data_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input int a);
    logic [31:0] w;
    w = 32'hDEADBEEF ^ (a * 32'h01010101);
    return {w, ~w, w, ~w};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // BRAM: unwritten words read back as init_word(addr).
  bit [DW-1:0] bram   [DEPTH];
  bit          bram_v [DEPTH];
  always @(posedge clk) begin
    if (mem_we) begin
      bram[mem_addr]   <= mem_data_in;
      bram_v[mem_addr] <= 1'b1;
    end
    if (mem_re) mem_data_out <= bram_v[mem_addr] ? bram[mem_addr] : init_word(int'(mem_addr));
  end

  // Reference model: timing from the accept cycle, contents in a shadow memory.
  bit [DW-1:0] ref_mem   [DEPTH];
  bit          ref_v     [DEPTH];
  int          m_mode  = 0;  // 0 idle, 1 store, 2 load
  int          m_t, m_base, m_len, m_wbeat;
  bit          m_rv    = 1'b0;
  bit          m_done  = 1'b0;
  logic [DW-1:0] m_rdata;

  always @(negedge clk) begin
    bit e_idle, e_wr, e_we, e_re, chk_addr, rv_n, done_n;
    int e_addr;
    if (rst) begin
      chk("rst_req_ready", DW'(bus.req_ready), DW'(1));
      chk("rst_busy", DW'(bus.busy), '0);
      chk("rst_done", DW'(bus.done), '0);
      chk("rst_wdata_ready", DW'(bus.wdata_ready), '0);
      chk("rst_mem_we", DW'(mem_we), '0);
      chk("rst_mem_re", DW'(mem_re), '0);
      chk("rst_mem_addr", DW'(mem_addr), '0);
      chk("rst_rdata_valid", DW'(bus.rdata_valid), '0);
      m_mode = 0;
      m_rv   = 1'b0;
      m_done = 1'b0;
    end else begin
      e_idle   = (m_mode == 0);
      e_wr     = (m_mode == 1);
      e_we     = e_wr && bus.wdata_valid;
      e_re     = (m_mode == 2) && (m_t <= m_len + 1);
      chk_addr = 1'b1;
      e_addr   = 0;
      if (e_wr) e_addr = (m_base + m_wbeat) % DEPTH;
      else if (e_re) e_addr = (m_base + m_t - 1) % DEPTH;
      else if (m_mode == 2) chk_addr = 1'b0;
      chk("req_ready", DW'(bus.req_ready), DW'(e_idle));
      chk("busy", DW'(bus.busy), DW'(!e_idle));
      chk("done", DW'(bus.done), DW'(m_done));
      chk("wdata_ready", DW'(bus.wdata_ready), DW'(e_wr));
      chk("mem_we", DW'(mem_we), DW'(e_we));
      chk("mem_re", DW'(mem_re), DW'(e_re));
      chk("rdata_valid", DW'(bus.rdata_valid), DW'(m_rv));
      if (chk_addr) chk("mem_addr", DW'(mem_addr), DW'(e_addr));
      if (e_wr) chk("mem_data_in", mem_data_in, bus.wdata);
      if (m_rv) chk("rdata", bus.rdata, m_rdata);
      rv_n   = e_re;
      done_n = 1'b0;
      if (e_re) m_rdata = ref_v[e_addr] ? ref_mem[e_addr] : init_word(e_addr);
      case (m_mode)
        1: if (bus.wdata_valid) begin
          ref_mem[e_addr] = bus.wdata;
          ref_v[e_addr]   = 1'b1;
          if (m_wbeat == m_len) begin
            m_mode = 0;
            done_n = 1'b1;
          end else m_wbeat++;
        end
        2: if (m_t == m_len + 2) begin
          m_mode = 0;
          done_n = 1'b1;
        end else m_t++;
        default: if (bus.req_valid) begin
          m_mode  = bus.req_we ? 1 : 2;
          m_base  = int'(bus.req_addr);
          m_len   = int'(bus.req_len);
          m_t     = 1;
          m_wbeat = 0;
        end
      endcase
      m_rv   = rv_n;
      m_done = done_n;
    end
  end

  // Event logs for the directed literal checks.
  logic [DW-1:0] rq[$];
  int            rvc[$];
  int            wq[$];
  int            dq[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rdata_valid) begin
        rq.push_back(bus.rdata);
        rvc.push_back(cyc);
      end
      if (mem_we) wq.push_back(int'(mem_addr));
      if (bus.done) dq.push_back(cyc);
    end
  end

  logic [DW-1:0] bdata [16];
  int            acc_cyc;

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic do_req(input bit we, input int addr, input int len);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = AW'(addr);
    bus.req_len   = LW'(len);
    @(negedge clk);
    while (!bus.req_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) chk("req_accept_timeout", DW'(bus.req_ready), DW'(1));
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // gap_mode: 0 none, 1 random, 2 two idle cycles before beat 2.
  task automatic store_burst(input int addr, input int len, input int gap_mode);
    int g;
    do_req(1'b1, addr, len);
    for (int i = 0; i <= len; i++) begin
      g = (gap_mode == 1) ? $urandom_range(0, 2) : ((gap_mode == 2 && i == 2) ? 2 : 0);
      bus.wdata_valid = 1'b0;
      bus.wdata       = {4{$urandom}};
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      bus.wdata_valid = 1'b1;
      bus.wdata       = bdata[i];
      @(posedge clk);
      #1;
    end
    bus.wdata_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) chk("wait_idle_timeout", DW'(bus.busy), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r0, w0, d0, a1, a2;
    bit found;
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_we      = 1'b0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.wdata       = '0;
    bus.wdata_valid = 1'b0;
    #2;
    chk("lit_reset_req_ready", DW'(bus.req_ready), DW'(1));
    chk("lit_reset_busy", DW'(bus.busy), '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-beat store then load.
    d0 = dq.size();
    w0 = wq.size();
    bdata[0] = {16{8'hA5}};
    store_burst(1, 0, 0);
    wait_idle();
    r0 = rq.size();
    do_req(1'b0, 1, 0);
    a1 = acc_cyc;
    wait_idle();
    chk("lit_s1_we_count", DW'(wq.size() - w0), DW'(1));
    chk("lit_s1_rv_count", DW'(rq.size() - r0), DW'(1));
    chk("lit_s1_rdata", rq[r0], {16{8'hA5}});
    chk("lit_s1_latency", DW'(rvc[r0] - a1), DW'(2));
    chk("lit_s1_done_count", DW'(dq.size() - d0), DW'(2));

    // Four-beat store with a gap, then load back.
    for (int i = 0; i < 4; i++) bdata[i] = {16{8'(8'h10 + i)}};
    w0 = wq.size();
    store_burst(16, 3, 2);
    wait_idle();
    chk("lit_s2_we_count", DW'(wq.size() - w0), DW'(4));
    for (int i = 0; i < 4; i++) chk("lit_s2_addr", DW'(wq[w0 + i]), DW'(16 + i));
    r0 = rq.size();
    do_req(1'b0, 16, 3);
    wait_idle();
    chk("lit_s3_rv_count", DW'(rq.size() - r0), DW'(4));
    for (int i = 0; i < 4; i++) chk("lit_s3_rdata", rq[r0 + i], {16{8'(8'h10 + i)}});
    for (int i = 1; i < 4; i++) chk("lit_s3_consecutive", DW'(rvc[r0 + i] - rvc[r0 + i - 1]), DW'(1));

    // Address wrap.
    for (int i = 0; i < 3; i++) bdata[i] = {16{8'h5A}};
    w0 = wq.size();
    store_burst(254, 2, 0);
    wait_idle();
    chk("lit_s4_addr0", DW'(wq[w0]), DW'(8'hFE));
    chk("lit_s4_addr1", DW'(wq[w0 + 1]), DW'(8'hFF));
    chk("lit_s4_addr2", DW'(wq[w0 + 2]), DW'(8'h00));
    r0 = rq.size();
    do_req(1'b0, 254, 2);
    wait_idle();
    for (int i = 0; i < 3; i++) chk("lit_s4_rdata", rq[r0 + i], {16{8'h5A}});

    // Reset during a long load.
    d0 = dq.size();
    r0 = rq.size();
    do_req(1'b0, 8'h30, 7);
    begin
      int n;
      n = 0;
      while (rq.size() < r0 + 2 && n < 50) begin
        n++;
        @(negedge clk);
      end
      if (n >= 50) chk("s5_return_timeout", DW'(rq.size() - r0), DW'(2));
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("lit_s5_busy", DW'(bus.busy), '0);
    chk("lit_s5_mem_re", DW'(mem_re), '0);
    chk("lit_s5_rdata_valid", DW'(bus.rdata_valid), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("lit_s5_no_done", DW'(dq.size() - d0), '0);
    r0 = rq.size();
    do_req(1'b0, 2, 0);
    wait_idle();
    chk("lit_s5_rdata", rq[r0], init_word(2));
    chk("lit_s5_done_after", DW'(dq.size() - d0), DW'(1));

    // Back-to-back: second request held during the first burst.
    d0 = dq.size();
    do_req(1'b0, 16, 3);
    do_req(1'b0, 32, 1);
    a2 = acc_cyc;
    wait_idle();
    found = 1'b0;
    if (dq.size() > d0) found = (dq[d0] == a2);
    chk("lit_s6_accept_in_done", DW'(found), DW'(1));

    // Random bursts.
    for (int b = 0; b < 80; b++) begin
      int len;
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) bdata[i] = {$urandom, $urandom, $urandom, $urandom};
        store_burst($urandom_range(0, 255), len, 1);
      end else begin
        do_req(1'b0, $urandom_range(0, 255), len);
      end
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
